ppu_bg_fetch_sequencer: RTL and testbench
=========================================

PPU_BG_FETCH_SEQUENCER -- requirements
Module: ppu_bg_fetch_sequencer

Interface
REQ-001 SHALL have parameter NT_BASE, default 14'h2000: nametable base OR-ed into nametable fetch addresses.
REQ-002 SHALL have port i_clk, input, 1: sole clock; all state changes on the rising edge.
REQ-003 SHALL have port i_reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port i_ce, input, 1: PPU dot enable; the sequencer advances only on edges where i_ce=1.
REQ-005 SHALL have port i_fetch_enable, input, 1: rendering enabled and dot inside a background fetch window.
REQ-006 SHALL have port i_v, input, 15: loopy v; [4:0] coarse X, [9:5] coarse Y, [11:10] nametable select, [14:12] fine Y.
REQ-007 SHALL have port i_bg_table, input, 1: background pattern table select (PPUCTRL bit 4).
REQ-008 SHALL have port i_data, input, 8: VRAM read data.
REQ-009 SHALL have port o_address, output, 14: VRAM fetch address.
REQ-010 SHALL have port o_rd, output, 1: read strobe.
REQ-011 SHALL have port o_nt, output, 8: latched nametable byte.
REQ-012 SHALL have port o_at, output, 2: latched 2-bit attribute palette for the current tile.
REQ-013 SHALL have port o_pt_lo and o_pt_hi, output, 8 each: latched pattern bitplanes.
REQ-014 SHALL have port o_tile_valid, output, 1: one-cycle pulse marking a completed tile.
REQ-015 SHALL have port o_inc_coarse_x, output, 1: one-cycle pulse requesting coarse-X increment of v.
REQ-016 SHALL have port o_tile_count, output, 16: completed-tile counter (see Configuration).

Function
REQ-017 SHALL hold a 3-bit phase counter 0..7; on an edge with i_ce=1 and i_fetch_enable=1 it increments, wrapping 7->0.
REQ-018 SHALL, on an edge with i_ce=1 and i_fetch_enable=0, force phase to 0 and discard any partial tile (no tile_valid, no inc pulse; o_nt/o_at/o_pt_* retain their values).
REQ-019 SHALL, for phases 0/1, drive o_address = NT_BASE | i_v[11:0].
REQ-020 SHALL, for phases 2/3, drive o_address = 14'h23C0 | {i_v[11:10],4'b0,i_v[9:7],3'b0} | i_v[4:2].
REQ-021 SHALL, for phases 4/5, drive o_address = {1'b0,i_bg_table,o_nt,1'b0,i_v[14:12]}.
REQ-022 SHALL, for phases 6/7, drive o_address = phase-4/5 address | 14'h0008.
REQ-023 SHALL drive o_address and o_rd combinationally from the phase register and inputs; o_rd=1 only in even phases while i_fetch_enable=1.
REQ-024 SHALL sample i_data on the advancing edge leaving odd phases: phase 1 -> o_nt; 3 -> o_at; 5 -> o_pt_lo; 7 -> o_pt_hi.
REQ-025 SHALL compute o_at = (i_data >> {i_v[6],i_v[1],1'b0}) & 2'b11, using i_v as sampled on the phase-3 edge.
REQ-026 SHALL assert o_tile_valid and o_inc_coarse_x for exactly one clock following the phase 7->0 advancing edge; with i_ce=0 they fall the next clock regardless.
REQ-027 SHALL ignore i_data and hold all state on edges where i_ce=0.

Reset
REQ-028 SHALL, while i_reset=1 at an edge, set phase=0, o_nt=o_at=o_pt_lo=o_pt_hi=0, o_tile_valid=o_inc_coarse_x=0, o_tile_count=0.
REQ-029 SHALL give reset priority over i_ce and i_fetch_enable; a reset mid-tile discards the tile with no pulses.
REQ-030 SHALL resume at phase 0 on the first advancing edge after reset deasserts.

Configuration
REQ-031 SHALL, with macro PPU_BG_FETCH_TILE_COUNT_EN defined, increment o_tile_count by 1 (modulo 2^16, 16'hFFFF -> 0) per o_tile_valid pulse.
REQ-032 SHALL, without PPU_BG_FETCH_TILE_COUNT_EN, tie o_tile_count to 16'h0000 and contain no counter logic.

Verification
REQ-033 SHALL cover: reset, i_v=15'h0000, enable, i_ce=1 -> phase 0 o_address=14'h2000 o_rd=1; phase 2 o_address=14'h23C0.
REQ-034 SHALL cover: i_v=15'h0065, i_data=8'hE4 at phase 3 -> AT address 14'h23C1, o_at=2'b10.
REQ-035 SHALL cover: i_v=15'h3000, i_bg_table=1, NT data 8'h41 -> PT addresses 14'h1413 then 14'h141B; tile_valid and inc_coarse_x single-cycle pulse after phase 7.
REQ-036 SHALL cover: i_fetch_enable dropped at phase 5 -> phase returns to 0, no tile_valid, o_pt_lo unchanged.
REQ-037 SHALL cover: i_ce toggling 1/0 every clock over 16 enabled dots -> exactly 2 tile_valid pulses, each one clock wide.
REQ-038 SHALL cover: with PPU_BG_FETCH_TILE_COUNT_EN, 3 tiles -> o_tile_count=3; i_reset at phase 4 -> count 0, phase 0; without the macro, o_tile_count=0 throughout.

Source files
------------

// File: rtl/ppu_bg_fetch_sequencer.sv
// PPU background fetch sequencer: eight-dot NT/AT/PT-lo/PT-hi fetch cycle.
// Ports: i_clk/i_reset/i_ce, i_fetch_enable, i_v, i_bg_table, i_data in;
//   o_address/o_rd, o_nt/o_at/o_pt_lo/o_pt_hi, o_tile_valid, o_inc_coarse_x,
//   o_tile_count out. PPU_BG_FETCH_TILE_COUNT_EN enables the tile counter.
module ppu_bg_fetch_sequencer #(
  parameter logic [13:0] NT_BASE = 14'h2000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_ce,
  input  logic        i_fetch_enable,
  input  logic [14:0] i_v,
  input  logic        i_bg_table,
  input  logic [7:0]  i_data,
  output logic [13:0] o_address,
  output logic        o_rd,
  output logic [7:0]  o_nt,
  output logic [1:0]  o_at,
  output logic [7:0]  o_pt_lo,
  output logic [7:0]  o_pt_hi,
  output logic        o_tile_valid,
  output logic        o_inc_coarse_x,
  output logic [15:0] o_tile_count
);

  typedef enum logic [2:0] {
    PH_NT0, PH_NT1,
    PH_AT0, PH_AT1,
    PH_LO0, PH_LO1,
    PH_HI0, PH_HI1
  } phase_t;

  phase_t phase_q;
  phase_t phase_d;

  logic        advance;
  logic        tile_done;
  logic [13:0] pt_addr;
  logic [7:0]  at_shifted;

  assign advance   = i_ce & i_fetch_enable;
  assign tile_done = advance && (phase_q == PH_HI1);

  // Quadrant select: v[6] picks top/bottom, v[1] picks left/right.
  assign at_shifted = i_data >> {i_v[6], i_v[1], 1'b0};

  // Uses the latched NT byte; the hi plane adds 8 below.
  assign pt_addr = {1'b0, i_bg_table, o_nt, 1'b0, i_v[14:12]};

  always_ff @(posedge i_clk) begin
    if (i_reset) phase_q <= PH_NT0;
    else         phase_q <= phase_d;
  end

  always_comb begin
    phase_d = phase_q;
    if (i_ce) begin
      if (!i_fetch_enable) begin
        phase_d = PH_NT0;
      end else begin
        unique case (phase_q)
          PH_NT0: phase_d = PH_NT1;
          PH_NT1: phase_d = PH_AT0;
          PH_AT0: phase_d = PH_AT1;
          PH_AT1: phase_d = PH_LO0;
          PH_LO0: phase_d = PH_LO1;
          PH_LO1: phase_d = PH_HI0;
          PH_HI0: phase_d = PH_HI1;
          PH_HI1: phase_d = PH_NT0;
        endcase
      end
    end
  end

  always_comb begin
    o_address = NT_BASE | {2'b00, i_v[11:0]};
    unique case (phase_q)
      PH_NT0, PH_NT1: o_address = NT_BASE | {2'b00, i_v[11:0]};
      PH_AT0, PH_AT1: o_address = 14'h23C0
                                | {2'b00, i_v[11:10], 4'b0000,
                                   i_v[9:7], 3'b000}
                                | {11'd0, i_v[4:2]};
      PH_LO0, PH_LO1: o_address = pt_addr;
      PH_HI0, PH_HI1: o_address = pt_addr | 14'h0008;
    endcase
  end

  assign o_rd = i_fetch_enable & ~phase_q[0];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_nt           <= 8'h00;
      o_at           <= 2'b00;
      o_pt_lo        <= 8'h00;
      o_pt_hi        <= 8'h00;
      o_tile_valid   <= 1'b0;
      o_inc_coarse_x <= 1'b0;
    end else begin
      o_tile_valid   <= tile_done;
      o_inc_coarse_x <= tile_done;
      if (advance) begin
        unique case (phase_q)
          PH_NT1:  o_nt    <= i_data;
          PH_AT1:  o_at    <= at_shifted[1:0];
          PH_LO1:  o_pt_lo <= i_data;
          PH_HI1:  o_pt_hi <= i_data;
          default: ;
        endcase
      end
    end
  end

`ifdef PPU_BG_FETCH_TILE_COUNT_EN
  logic [15:0] tile_count_q;

  always_ff @(posedge i_clk) begin
    if (i_reset)        tile_count_q <= 16'h0000;
    else if (tile_done) tile_count_q <= tile_count_q + 16'h0001;
  end

  assign o_tile_count = tile_count_q;
`else
  assign o_tile_count = 16'h0000;
`endif

endmodule

// File: tb/tb_ppu_bg_fetch_sequencer.sv
// Scoreboard bench for ppu_bg_fetch_sequencer.
// Expectations are queued with stimulus and drained against DUT outputs.
module tb_ppu_bg_fetch_sequencer;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_ce;
  logic        i_fetch_enable;
  logic [14:0] i_v;
  logic        i_bg_table;
  logic [7:0]  i_data;
  logic [13:0] o_address;
  logic        o_rd;
  logic [7:0]  o_nt;
  logic [1:0]  o_at;
  logic [7:0]  o_pt_lo;
  logic [7:0]  o_pt_hi;
  logic        o_tile_valid;
  logic        o_inc_coarse_x;
  logic [15:0] o_tile_count;

  ppu_bg_fetch_sequencer dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_ce           (i_ce),
    .i_fetch_enable (i_fetch_enable),
    .i_v            (i_v),
    .i_bg_table     (i_bg_table),
    .i_data         (i_data),
    .o_address      (o_address),
    .o_rd           (o_rd),
    .o_nt           (o_nt),
    .o_at           (o_at),
    .o_pt_lo        (o_pt_lo),
    .o_pt_hi        (o_pt_hi),
    .o_tile_valid   (o_tile_valid),
    .o_inc_coarse_x (o_inc_coarse_x),
    .o_tile_count   (o_tile_count)
  );

  always #5 i_clk = ~i_clk;

  localparam int S_ADDR = 0;
  localparam int S_RD   = 1;
  localparam int S_NT   = 2;
  localparam int S_AT   = 3;
  localparam int S_LO   = 4;
  localparam int S_HI   = 5;
  localparam int S_TV   = 6;
  localparam int S_INC  = 7;
  localparam int S_CNT  = 8;

`ifdef PPU_BG_FETCH_TILE_COUNT_EN
  localparam logic [15:0] CNT3 = 16'd3;
`else
  localparam logic [15:0] CNT3 = 16'd0;
`endif

  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check_eq(string tag, logic [15:0] got,
                          logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] obs(int sel);
    case (sel)
      S_ADDR:  return {2'b00, o_address};
      S_RD:    return {15'd0, o_rd};
      S_NT:    return {8'd0, o_nt};
      S_AT:    return {14'd0, o_at};
      S_LO:    return {8'd0, o_pt_lo};
      S_HI:    return {8'd0, o_pt_hi};
      S_TV:    return {15'd0, o_tile_valid};
      S_INC:   return {15'd0, o_inc_coarse_x};
      default: return o_tile_count;
    endcase
  endfunction

  task automatic push(string tag, int sel, logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq(e.tag, obs(e.sel), e.val);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // One enabled dot: check comb address/strobe, then clock it.
  task automatic dot(string tag, logic [7:0] d,
                     logic [13:0] ea, logic er);
    i_data = d;
    push({tag, "_addr"}, S_ADDR, {2'b00, ea});
    push({tag, "_rd"}, S_RD, {15'd0, er});
    #1;
    drain();
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  int pulses;
  int wide;
  logic prev;

  initial begin
    i_reset = 1'b1;
    i_ce = 1'b1;
    i_fetch_enable = 1'b0;
    i_v = 15'h0000;
    i_bg_table = 1'b0;
    i_data = 8'h00;
    tick();
    tick();
    push("rst_nt", S_NT, 16'h0);
    push("rst_at", S_AT, 16'h0);
    push("rst_lo", S_LO, 16'h0);
    push("rst_hi", S_HI, 16'h0);
    push("rst_tv", S_TV, 16'h0);
    push("rst_inc", S_INC, 16'h0);
    push("rst_cnt", S_CNT, 16'h0);
    push("rst_rd", S_RD, 16'h0);
    drain();

    i_reset = 1'b0;
    i_fetch_enable = 1'b1;
    dot("t1p0", 8'h00, 14'h2000, 1'b1);
    i_ce = 1'b0;
    i_data = 8'hEE;
    tick();
    push("hold_nt", S_NT, 16'h0);
    push("hold_addr", S_ADDR, 16'h2000);
    push("hold_rd", S_RD, 16'h0);
    drain();
    i_ce = 1'b1;
    dot("t1p1", 8'h12, 14'h2000, 1'b0);
    dot("t1p2", 8'h00, 14'h23C0, 1'b1);
    i_v = 15'h0065;
    dot("t1p3", 8'hE4, 14'h23C1, 1'b0);
    push("t1_at", S_AT, 16'h2);
    drain();
    dot("t1p4", 8'h00, 14'h0120, 1'b1);
    dot("t1p5", 8'hA5, 14'h0120, 1'b0);
    dot("t1p6", 8'h00, 14'h0128, 1'b1);
    dot("t1p7", 8'h5A, 14'h0128, 1'b0);
    push("t1_tv", S_TV, 16'h1);
    push("t1_inc", S_INC, 16'h1);
    push("t1_nt", S_NT, 16'h12);
    push("t1_lo", S_LO, 16'hA5);
    push("t1_hi", S_HI, 16'h5A);
    drain();
    i_ce = 1'b0;
    tick();
    push("t1_tv_fall", S_TV, 16'h0);
    push("t1_inc_fall", S_INC, 16'h0);
    push("t1_wrap_addr", S_ADDR, 16'h2065);
    drain();

    i_ce = 1'b1;
    i_v = 15'h3000;
    i_bg_table = 1'b1;
    dot("t2p0", 8'h00, 14'h2000, 1'b1);
    dot("t2p1", 8'h41, 14'h2000, 1'b0);
    dot("t2p2", 8'h00, 14'h23C0, 1'b1);
    dot("t2p3", 8'hFF, 14'h23C0, 1'b0);
    dot("t2p4", 8'h00, 14'h1413, 1'b1);
    dot("t2p5", 8'h3C, 14'h1413, 1'b0);
    dot("t2p6", 8'h00, 14'h141B, 1'b1);
    dot("t2p7", 8'hC3, 14'h141B, 1'b0);
    push("t2_tv", S_TV, 16'h1);
    push("t2_inc", S_INC, 16'h1);
    push("t2_at", S_AT, 16'h3);
    push("t2_lo", S_LO, 16'h3C);
    push("t2_hi", S_HI, 16'hC3);
    drain();
    tick();
    push("t2_tv_1cyc", S_TV, 16'h0);
    push("t2_inc_1cyc", S_INC, 16'h0);
    drain();
    i_fetch_enable = 1'b0;
    tick();

    i_fetch_enable = 1'b1;
    for (int p = 0; p < 5; p++) begin
      i_data = (p == 1) ? 8'h77 : 8'h00;
      tick();
    end
    i_fetch_enable = 1'b0;
    i_data = 8'h99;
    #1;
    push("drop_rd", S_RD, 16'h0);
    drain();
    tick();
    push("drop_lo", S_LO, 16'h3C);
    push("drop_nt", S_NT, 16'h77);
    push("drop_tv", S_TV, 16'h0);
    drain();
    i_fetch_enable = 1'b1;
    #1;
    push("drop_ph0_addr", S_ADDR, 16'h2000);
    push("drop_ph0_rd", S_RD, 16'h1);
    drain();
    tick();
    push("drop_no_tv", S_TV, 16'h0);
    drain();
    i_fetch_enable = 1'b0;
    tick();

    i_fetch_enable = 1'b1;
    pulses = 0;
    wide = 0;
    prev = 1'b0;
    for (int k = 0; k < 32; k++) begin
      i_ce = (k % 2 == 0);
      tick();
      if (o_tile_valid) begin
        if (prev) wide++;
        else pulses++;
      end
      prev = o_tile_valid;
    end
    check_eq("ce_toggle_pulses", pulses[15:0], 16'd2);
    check_eq("ce_toggle_wide", wide[15:0], 16'd0);

    i_ce = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    i_reset = 1'b1;
    tick();
    push("mid_rst_nt", S_NT, 16'h0);
    push("mid_rst_lo", S_LO, 16'h0);
    push("mid_rst_hi", S_HI, 16'h0);
    push("mid_rst_tv", S_TV, 16'h0);
    push("mid_rst_cnt", S_CNT, 16'h0);
    drain();
    i_reset = 1'b0;
    #1;
    push("mid_rst_ph0", S_ADDR, 16'h2000);
    drain();
    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < 8; k++) tick();
    end
    push("cnt3_tv", S_TV, 16'h1);
    push("cnt3", S_CNT, CNT3);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
